// File: rtl/dff_response_checker.sv
// dff_response_checker: predicts the output of a D flip-flop under test
// as D delayed LAT cycles. It compares that prediction with the observed
// Q and keeps sticky/count statistics. After MAX_ERR miscompares it locks
// into FAIL until clr or rst_n.
module dff_response_checker #(
  parameter int unsigned LAT     = 1,
  parameter int unsigned MAX_ERR = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic        D,
  input  logic        Q,
  output logic        expected_q,
  output logic        mismatch,
  output logic        err_sticky,
  output logic [7:0]  err_count,
  output logic [15:0] check_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_WARMUP = 2'b01,
    S_CHECK  = 2'b10,
    S_FAIL   = 2'b11
  } state_t;

  localparam logic [2:0] WARM_LAST = 3'(LAT - 1);
  localparam logic [7:0] ERR_LIMIT = 8'(MAX_ERR);

  state_t         st, st_nxt;
  logic [LAT-1:0] d_pipe, v_pipe;
  logic [LAT:0]   d_shift, v_shift;
  logic [2:0]     warm_cnt, warm_nxt;
  logic           shift, flush, do_cmp, miss;
  logic [7:0]     err_inc;

  assign d_shift    = {d_pipe, D};
  assign v_shift    = {v_pipe, 1'b1};
  assign expected_q = d_pipe[LAT-1];
  assign state      = st;

  // Miscompare detect and saturating error increment
  always_comb begin
    miss    = (Q != d_pipe[LAT-1]);
    err_inc = (err_count == 8'hFF) ? 8'hFF : err_count + 8'd1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= st_nxt;
  end

  // Next-state, pipeline control and compare strobe
  always_comb begin
    st_nxt   = st;
    warm_nxt = warm_cnt;
    shift    = 1'b0;
    flush    = 1'b0;
    do_cmp   = 1'b0;
    if (clr) begin
      st_nxt   = S_IDLE;
      warm_nxt = '0;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (en) begin
            st_nxt   = S_WARMUP;
            warm_nxt = '0;
            shift    = 1'b1;
          end
        end
        S_WARMUP: begin
          if (!en) begin
            st_nxt = S_IDLE;
            flush  = 1'b1;
          end else begin
            shift = 1'b1;
            if (warm_cnt == WARM_LAST) begin
              st_nxt   = S_CHECK;
              warm_nxt = '0;
            end else begin
              warm_nxt = warm_cnt + 3'd1;
            end
          end
        end
        S_CHECK: begin
          if (!en) begin
            st_nxt = S_IDLE;
            flush  = 1'b1;
          end else begin
            shift  = 1'b1;
            do_cmp = v_pipe[LAT-1];
            // The FSM enters FAIL on the same edge that the count reaches the limit.
            if (do_cmp && miss && (err_inc >= ERR_LIMIT)) st_nxt = S_FAIL;
          end
        end
        S_FAIL: begin
          st_nxt = S_FAIL;
        end
        default: st_nxt = S_IDLE;
      endcase
    end
  end

  // Pipelines, warm-up counter, statistics and mismatch pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_pipe      <= '0;
      v_pipe      <= '0;
      warm_cnt    <= '0;
      mismatch    <= 1'b0;
      err_sticky  <= 1'b0;
      err_count   <= '0;
      check_count <= '0;
    end else if (clr) begin
      d_pipe      <= '0;
      v_pipe      <= '0;
      warm_cnt    <= '0;
      mismatch    <= 1'b0;
      err_sticky  <= 1'b0;
      err_count   <= '0;
      check_count <= '0;
    end else begin
      warm_cnt <= warm_nxt;
      mismatch <= do_cmp & miss;
      if (shift) begin
        d_pipe <= d_shift[LAT-1:0];
        v_pipe <= v_shift[LAT-1:0];
      end else if (flush) begin
        v_pipe <= '0;
      end
      if (do_cmp) begin
        if (check_count != 16'hFFFF) check_count <= check_count + 16'd1;
        if (miss) begin
          err_sticky <= 1'b1;
          err_count  <= err_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_dff_response_checker.sv
// Bench for dff_response_checker. Two instances share the stimulus:
//   u_a: LAT=1, MAX_ERR=8
//   u_b: LAT=3, MAX_ERR=2
// Each Q is a bench flop chain of D, optionally inverted to inject errors.
module tb_dff_response_checker;

  logic clk = 1'b0;
  logic rst_n, en, clr, d, flip_a, flip_b;
  logic [2:0] dly = '0;
  logic q_a, q_b;

  logic        eq_a, mm_a, sk_a, eq_b, mm_b, sk_b;
  logic [7:0]  err_a, err_b;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  st_a, st_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Reference flip-flop chain that stands in for the device under test
  always @(posedge clk) dly <= {dly[1:0], d};

  assign q_a = dly[0] ^ flip_a;
  assign q_b = dly[2] ^ flip_b;

  dff_response_checker #(.LAT(1), .MAX_ERR(8)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .D(d), .Q(q_a),
    .expected_q(eq_a), .mismatch(mm_a), .err_sticky(sk_a),
    .err_count(err_a), .check_count(cnt_a), .state(st_a));

  dff_response_checker #(.LAT(3), .MAX_ERR(2)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .D(d), .Q(q_b),
    .expected_q(eq_b), .mismatch(mm_b), .err_sticky(sk_b),
    .err_count(err_b), .check_count(cnt_b), .state(st_b));

  // Behavioural model.
  // ph: 0 idle, 1 warm-up, 2 check, 3 fail.
  // warm_left: warm-up edges still to go.
  // nvalid: number of valid history entries.
  typedef struct {
    int       lat;
    int       maxe;
    int       ph;
    bit [3:0] hist;
    int       nvalid;
    int       warm_left;
    bit       mm;
    bit       sticky;
    int       errc;
    int       chk;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mreset(int lat, int maxe);
    mdl_t m;
    m.lat = lat; m.maxe = maxe; m.ph = 0; m.hist = '0; m.nvalid = 0;
    m.warm_left = 0; m.mm = 0; m.sticky = 0; m.errc = 0; m.chk = 0;
    return m;
  endfunction

  function automatic mdl_t mpush(mdl_t m, bit dv);
    mdl_t n = m;
    n.hist = {m.hist[2:0], dv};
    n.nvalid = (m.nvalid + 1 > m.lat) ? m.lat : m.nvalid + 1;
    return n;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit e, bit c, bit dv, bit qv);
    mdl_t n = m;
    bit   pred = m.hist[m.lat-1];
    n.mm = 0;
    if (c) return mreset(m.lat, m.maxe);
    case (m.ph)
      0: if (e) begin
           n = mpush(n, dv);
           n.ph = 1;
           n.warm_left = m.lat;
         end
      1: if (!e) begin
           n.ph = 0; n.nvalid = 0;
         end else begin
           n = mpush(n, dv);
           n.warm_left = m.warm_left - 1;
           if (n.warm_left == 0) n.ph = 2;
         end
      2: if (!e) begin
           n.ph = 0; n.nvalid = 0;
         end else begin
           if (m.nvalid >= m.lat) begin
             n.chk = (m.chk < 65535) ? m.chk + 1 : 65535;
             if (qv != pred) begin
               n.mm = 1; n.sticky = 1;
               n.errc = (m.errc < 255) ? m.errc + 1 : 255;
               if (n.errc >= m.maxe) n.ph = 3;
             end
           end
           n = mpush(n, dv);
         end
      default: ;
    endcase
    return n;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_both();
    chk("a.state", int'(st_a), ma.ph);
    chk("a.expected_q", int'(eq_a), int'(ma.hist[ma.lat-1]));
    chk("a.mismatch", int'(mm_a), int'(ma.mm));
    chk("a.err_sticky", int'(sk_a), int'(ma.sticky));
    chk("a.err_count", int'(err_a), ma.errc);
    chk("a.check_count", int'(cnt_a), ma.chk);
    chk("b.state", int'(st_b), mb.ph);
    chk("b.expected_q", int'(eq_b), int'(mb.hist[mb.lat-1]));
    chk("b.mismatch", int'(mm_b), int'(mb.mm));
    chk("b.err_sticky", int'(sk_b), int'(mb.sticky));
    chk("b.err_count", int'(err_b), mb.errc);
    chk("b.check_count", int'(cnt_b), mb.chk);
  endtask

  // Inputs are driven at the negedge before calling; this advances one
  // clock and compares at the following negedge.
  task automatic cycle();
    #1;
    ma = mstep(ma, en, clr, d, q_a);
    mb = mstep(mb, en, clr, d, q_b);
    @(posedge clk);
    @(negedge clk);
    check_both();
  endtask

  task automatic zeros_now(input string tag);
    chk({tag, ".a.state"}, int'(st_a), 0);
    chk({tag, ".a.expected_q"}, int'(eq_a), 0);
    chk({tag, ".a.mismatch"}, int'(mm_a), 0);
    chk({tag, ".a.err_sticky"}, int'(sk_a), 0);
    chk({tag, ".a.err_count"}, int'(err_a), 0);
    chk({tag, ".a.check_count"}, int'(cnt_a), 0);
    chk({tag, ".b.state"}, int'(st_b), 0);
    chk({tag, ".b.check_count"}, int'(cnt_b), 0);
    chk({tag, ".b.err_count"}, int'(err_b), 0);
    chk({tag, ".b.err_sticky"}, int'(sk_b), 0);
  endtask

  // Directed vector record for instance a (LAT=1)
  typedef struct {
    bit e;
    bit dv;
    int st;
    int mm;
    int cnt;
    int err;
  } vec_t;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t vecs[8];
    int   npulse, nw, saved_cnt, saved_err, found, any_mm;

    vecs[0] = '{0, 0, 0, 0, 0, 0};
    vecs[1] = '{1, 0, 1, 0, 0, 0};
    vecs[2] = '{1, 1, 2, 0, 0, 0};
    vecs[3] = '{1, 0, 2, 0, 1, 0};
    vecs[4] = '{1, 1, 2, 0, 2, 0};
    vecs[5] = '{1, 0, 2, 0, 3, 0};
    vecs[6] = '{1, 1, 2, 0, 4, 0};
    vecs[7] = '{1, 0, 2, 0, 5, 0};

    rst_n = 0; en = 0; clr = 0; d = 0; flip_a = 0; flip_b = 0;
    ma = mreset(1, 8);
    mb = mreset(3, 2);
    @(negedge clk);
    @(negedge clk);
    zeros_now("reset");
    check_both();
    rst_n = 1;

    // Clean toggling with correct Q, LAT=1 instance
    foreach (vecs[i]) begin
      en = vecs[i].e;
      d  = vecs[i].dv;
      cycle();
      chk($sformatf("vec%0d.state", i), int'(st_a), vecs[i].st);
      chk($sformatf("vec%0d.mismatch", i), int'(mm_a), vecs[i].mm);
      chk($sformatf("vec%0d.check_count", i), int'(cnt_a), vecs[i].cnt);
      chk($sformatf("vec%0d.err_count", i), int'(err_a), vecs[i].err);
    end

    // Three forced miscompares on instance a
    d = 1;
    cycle();
    npulse = 0;
    flip_a = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      npulse += int'(mm_a);
    end
    flip_a = 0;
    cycle();
    npulse += int'(mm_a);
    chk("a.pulses", npulse, 3);
    chk("a.err3", int'(err_a), 3);
    chk("a.sticky3", int'(sk_a), 1);
    chk("a.still_check", int'(st_a), 2);

    // Continuous inversion on instance b (MAX_ERR=2) drives it into FAIL
    flip_b = 1;
    found = 0;
    for (int i = 0; i < 12 && found == 0; i++) begin
      d = 1'($urandom);
      cycle();
      if (st_b == 2'b11) found = 1;
    end
    chk("b.fail_reached", found, 1);
    chk("b.fail_err", int'(err_b), 2);
    chk("b.fail_pulse", int'(mm_b), 1);
    saved_cnt = int'(cnt_b);
    saved_err = int'(err_b);
    for (int i = 0; i < 4; i++) begin
      d  = 1'($urandom);
      en = (i != 1);
      cycle();
    end
    en = 1;
    chk("b.frozen_cnt", int'(cnt_b), saved_cnt);
    chk("b.frozen_err", int'(err_b), saved_err);
    chk("b.stays_fail", int'(st_b), 3);
    chk("b.fail_sticky", int'(sk_b), 1);
    chk("b.fail_nopulse", int'(mm_b), 0);

    // clr with en held, from FAIL
    clr = 1;
    cycle();
    clr = 0;
    flip_b = 0;
    chk("clr.b.state", int'(st_b), 0);
    chk("clr.b.err", int'(err_b), 0);
    chk("clr.b.cnt", int'(cnt_b), 0);
    chk("clr.b.sticky", int'(sk_b), 0);
    chk("clr.a.err", int'(err_a), 0);
    cycle();
    chk("clr.b.warmup", int'(st_b), 1);

    // en drop for one cycle in CHECK, LAT=3
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      d = 1'($urandom);
      cycle();
      if (st_b == 2'b10) found = 1;
    end
    chk("drop.b.in_check", found, 1);
    en = 0;
    d = 1'($urandom);
    cycle();
    chk("drop.b.idle", int'(st_b), 0);
    en = 1;
    nw = 0;
    any_mm = 0;
    for (int i = 0; i < 10; i++) begin
      d = 1'($urandom);
      cycle();
      any_mm |= int'(mm_b);
      if (st_b == 2'b01) nw++;
      if (st_b == 2'b10) break;
    end
    chk("drop.b.warm_cycles", nw, 3);
    for (int i = 0; i < 4; i++) begin
      d = 1'($urandom);
      cycle();
      any_mm |= int'(mm_b);
    end
    chk("drop.b.no_stale_mm", any_mm, 0);

    // Asynchronous reset between edges in CHECK
    d = 1;
    flip_a = 1;
    cycle();
    flip_a = 0;
    #2 rst_n = 0;
    #1 zeros_now("async");
    ma = mreset(1, 8);
    mb = mreset(3, 2);
    @(negedge clk);
    rst_n = 1;
    check_both();
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      d = 1'($urandom);
      cycle();
      if (st_b == 2'b01) nw++;
      if (st_b == 2'b10) break;
    end
    chk("rst.b.warm_cycles", nw, 3);
    chk("rst.b.no_cmp_yet", int'(cnt_b), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      en     = ($urandom_range(15) != 0);
      clr    = ($urandom_range(49) == 0);
      d      = 1'($urandom);
      flip_a = ($urandom_range(7) == 0);
      flip_b = ($urandom_range(11) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
